// File: rtl/count_sequencer.sv
// count_sequencer: configurable up/down counter sequencer with repetition count and pause/resume.
// Ports:
//   clk      in   clock, all state updates on rising edge
//   clr      in   synchronous active-low reset
//   load     in   capture tc_in/reps_in/dir (IDLE only)
//   tc_in    in   [3:0] terminal count value
//   reps_in  in   [3:0] repetitions per run, 0 = run until stopped
//   dir      in   0 = count up, 1 = count down
//   start    in   begin run from IDLE, resume from HOLD
//   stop     in   pause from RUN, abort from HOLD (wins over start)
//   count    out  [3:0] current count
//   rep_cnt  out  [3:0] completed repetitions, modulo 16
//   busy     out  high in RUN or HOLD
//   wrap     out  one-cycle pulse on each reload
//   done     out  one-cycle pulse at run completion
module count_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] tc_in,
    input  logic [3:0] reps_in,
    input  logic       dir,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] count,
    output logic [3:0] rep_cnt,
    output logic       busy,
    output logic       wrap,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
    state_t     state_q;
    logic [3:0] tc_q, reps_q, count_q, rep_cnt_q;
    logic       dir_q, busy_q, wrap_q, done_q;
    logic [3:0] term_val, start_val, rep_nxt;
    logic       at_term, last_rep;
    assign term_val  = dir_q ? 4'd0 : tc_q;
    assign start_val = dir_q ? tc_q : 4'd0;
    assign rep_nxt   = rep_cnt_q + 4'd1;
    assign at_term   = count_q == term_val;
    // reps_q == 0 means endless, so only a nonzero target can finish the run
    assign last_rep  = (reps_q != 4'd0) && (rep_nxt == reps_q);
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            tc_q      <= 4'hF;
            reps_q    <= 4'd0;
            dir_q     <= 1'b0;
            count_q   <= 4'd0;
            rep_cnt_q <= 4'd0;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // load has priority; start+stop counts as stop, which IDLE ignores
                    if (load) begin
                        tc_q   <= tc_in;
                        reps_q <= reps_in;
                        dir_q  <= dir;
                    end else if (start && !stop) begin
                        state_q   <= RUN;
                        count_q   <= start_val;
                        rep_cnt_q <= 4'd0;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    // stop outranks the terminal-edge reload/finish
                    if (stop) begin
                        state_q <= HOLD;
                    end else if (!at_term) begin
                        count_q <= dir_q ? count_q - 4'd1 : count_q + 4'd1;
                    end else if (last_rep) begin
                        state_q   <= DONE;
                        rep_cnt_q <= reps_q;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        count_q   <= start_val;
                        rep_cnt_q <= rep_nxt;
                        wrap_q    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state_q   <= IDLE;
                        count_q   <= 4'd0;
                        rep_cnt_q <= 4'd0;
                        busy_q    <= 1'b0;
                    end else if (start) begin
                        state_q <= RUN;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign count   = count_q;
    assign rep_cnt = rep_cnt_q;
    assign busy    = busy_q;
    assign wrap    = wrap_q;
    assign done    = done_q;
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed self-checking bench for count_sequencer.
module tb_count_sequencer;
    logic       clk = 1'b0;
    logic       clr, load, dir, start, stop;
    logic [3:0] tc_in, reps_in;
    logic [3:0] count, rep_cnt;
    logic       busy, wrap, done;
    int         vectors = 0;
    int         miscompares = 0;

    count_sequencer dut (
        .clk(clk), .clr(clr), .load(load), .tc_in(tc_in), .reps_in(reps_in),
        .dir(dir), .start(start), .stop(stop), .count(count), .rep_cnt(rep_cnt),
        .busy(busy), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] c, input logic [3:0] r,
                       input logic b, input logic w, input logic d);
        logic [10:0] obs, exp;
        obs = {count, rep_cnt, busy, wrap, done};
        exp = {c, r, b, w, d};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed count=%0d rep=%0d busy=%b wrap=%b done=%b, expected count=%0d rep=%0d busy=%b wrap=%b done=%b",
                   tag, count, rep_cnt, busy, wrap, done, c, r, b, w, d);
        end
    endtask

    task automatic cfg(input logic [3:0] tc, input logic [3:0] reps, input logic dr);
        load = 1'b1; tc_in = tc; reps_in = reps; dir = dr;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] ec [8];
        logic [3:0] er [8];
        ec = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
        er = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
        clr = 1'b0; load = 1'b0; dir = 1'b0; start = 1'b0; stop = 1'b0;
        tc_in = 4'd0; reps_in = 4'd0;
        tick(); tick();
        chk("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;

        // up count, tc=3, two repetitions
        cfg(4'd3, 4'd2, 1'b0);
        chk("cfg_idle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("up_E%0d", i), ec[i], er[i], 1'b1, i == 4, 1'b0);
        end
        tick();
        chk("up_done", 4'd3, 4'd2, 1'b0, 1'b0, 1'b1);
        tick();
        chk("up_idle", 4'd3, 4'd2, 1'b0, 1'b0, 1'b0);

        // down count, tc=5, one repetition
        cfg(4'd5, 4'd1, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        chk("dn_E0", 4'd5, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("dn_E%0d", i), 4'(5 - i), 4'd0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk("dn_done", 4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("dn_idle", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);

        // pause / resume / abort, tc=2 endless
        cfg(4'd2, 4'd0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        chk("hold_E0", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("hold_E1", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
        stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk($sformatf("hold_frz%0d", i), 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
        end
        start = 1'b1; tick(); start = 1'b0;
        chk("hold_resume", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("hold_r2", 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("hold_wrap", 4'd0, 4'd1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("hold_r1", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        stop = 1'b1; tick();
        chk("hold_again", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); stop = 1'b0;
        chk("hold_abort", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // tc=0 endless: wrap every cycle, rep_cnt rolls over
        cfg(4'd0, 4'd0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        chk("tc0_E0", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("tc0_E%0d", i), 4'd0, 4'(i), 1'b1, 1'b1, 1'b0);
        end
        stop = 1'b1; tick(); tick(); stop = 1'b0;
        chk("tc0_abort", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // reset mid-run restores tc=15 / up
        cfg(4'd4, 4'd0, 1'b1);
        cfg(4'd4, 4'd0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("rst_pre", 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        clr = 1'b0; start = 1'b1; tick(); clr = 1'b1; start = 1'b0;
        chk("rst_mid", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        chk("rst_E0", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("rst_E%0d", i), 4'(i), 4'd0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk("rst_wrap", 4'd0, 4'd1, 1'b1, 1'b1, 1'b0);
        stop = 1'b1; tick(); tick(); stop = 1'b0;
        chk("rst_abort", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // load+start in IDLE loads only; load/start ignored in RUN; start+stop in HOLD aborts
        load = 1'b1; start = 1'b1; tc_in = 4'd7; reps_in = 4'd0; dir = 1'b0;
        tick(); load = 1'b0;
        chk("ls_idle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ls_run", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        load = 1'b1; tc_in = 4'd2; reps_in = 4'd1; dir = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("ign_E%0d", i), 4'(i), 4'd0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk("ign_wrap", 4'd0, 4'd1, 1'b1, 1'b1, 1'b0);
        tick();
        load = 1'b0; start = 1'b0;
        chk("ign_E9", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        stop = 1'b1; tick();
        chk("ss_hold", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("ss_abort", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_idle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
